// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one Rd/Wr + Done memory port between the instruction
//                fetch requester (I, read-only) and the data requester (D,
//                read/write). One access is in flight at a time. D has
//                priority, but after STARVE_MAX consecutive D grants with I
//                waiting, I is served next.
//  Ports       : clk, rst (async, active-low)
//                I side : i_req, i_addr, i_flush -> i_done, i_rdata, i_err, i_stall
//                D side : d_req, d_wr, d_addr, d_wdata -> d_done, d_rdata, d_err, d_stall
//                Memory : mem_rd, mem_wr, mem_addr, mem_wdata <- mem_dout, mem_done, mem_err
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction requester
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    output logic              i_stall,
    // data requester
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              d_stall,
    // memory port
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_done,
    input  logic              mem_err
);

    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t                  r_state,     w_state_nxt;
    logic [c_STARVE_W-1:0]   r_starve,    w_starve_nxt;
    logic                    r_flush,     w_flush_nxt;
    logic                    r_mem_rd,    w_mem_rd_nxt;
    logic                    r_mem_wr,    w_mem_wr_nxt;
    logic [ADDR_W-1:0]       r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0]       r_mem_wdata, w_mem_wdata_nxt;
    logic                    r_i_done,    w_i_done_nxt;
    logic [DATA_W-1:0]       r_i_rdata,   w_i_rdata_nxt;
    logic                    r_i_err,     w_i_err_nxt;
    logic                    r_d_done,    w_d_done_nxt;
    logic [DATA_W-1:0]       r_d_rdata,   w_d_rdata_nxt;
    logic                    r_d_err,     w_d_err_nxt;

    logic                    w_grant_d;
    logic                    w_grant_i;

    // D wins unless I has already been passed over STARVE_MAX times.
    assign w_grant_d = d_req && ((r_starve < c_STARVE_MAX) || !i_req);
    assign w_grant_i = !w_grant_d && i_req && !i_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_starve    <= '0;
            r_flush     <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_done    <= 1'b0;
            r_i_rdata   <= '0;
            r_i_err     <= 1'b0;
            r_d_done    <= 1'b0;
            r_d_rdata   <= '0;
            r_d_err     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_starve    <= w_starve_nxt;
            r_flush     <= w_flush_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_i_done    <= w_i_done_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_i_err     <= w_i_err_nxt;
            r_d_done    <= w_d_done_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_d_err     <= w_d_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_starve_nxt    = r_starve;
        w_flush_nxt     = r_flush;
        w_mem_rd_nxt    = r_mem_rd;
        w_mem_wr_nxt    = r_mem_wr;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_i_done_nxt    = 1'b0;
        w_i_rdata_nxt   = r_i_rdata;
        w_i_err_nxt     = r_i_err;
        w_d_done_nxt    = 1'b0;
        w_d_rdata_nxt   = r_d_rdata;
        w_d_err_nxt     = r_d_err;

        case (r_state)
            ST_IDLE: begin
                w_flush_nxt  = 1'b0;
                w_mem_rd_nxt = 1'b0;
                w_mem_wr_nxt = 1'b0;
                if (!i_req) begin
                    w_starve_nxt = '0;
                end
                if (w_grant_d) begin
                    w_state_nxt     = ST_BUSY_D;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                    w_mem_rd_nxt    = !d_wr;
                    w_mem_wr_nxt    = d_wr;
                    // Only grants that bypass a waiting I count toward starvation.
                    if (i_req && (r_starve < c_STARVE_MAX)) begin
                        w_starve_nxt = r_starve + c_STARVE_W'(1);
                    end
                end else if (w_grant_i) begin
                    w_state_nxt     = ST_BUSY_I;
                    w_mem_addr_nxt  = i_addr;
                    w_mem_wdata_nxt = '0;
                    w_mem_rd_nxt    = 1'b1;
                    w_mem_wr_nxt    = 1'b0;
                    w_starve_nxt    = '0;
                end
            end

            ST_BUSY_I: begin
                if (i_flush) begin
                    w_flush_nxt = 1'b1;
                end
                // A flushed fetch still runs to completion on the memory side;
                // only its result is discarded (a flush on the final cycle counts too).
                if (mem_done) begin
                    w_state_nxt  = ST_IDLE;
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                    w_flush_nxt  = 1'b0;
                    if (!(r_flush || i_flush)) begin
                        w_i_done_nxt  = 1'b1;
                        w_i_rdata_nxt = mem_dout;
                        w_i_err_nxt   = mem_err;
                    end
                end
            end

            ST_BUSY_D: begin
                if (mem_done) begin
                    w_state_nxt  = ST_IDLE;
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                    w_d_done_nxt = 1'b1;
                    w_d_err_nxt  = mem_err;
                    if (!r_mem_wr) begin
                        w_d_rdata_nxt = mem_dout;
                    end
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_mem_rd_nxt = 1'b0;
                w_mem_wr_nxt = 1'b0;
            end
        endcase
    end

    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_done    = r_i_done;
    assign i_rdata   = r_i_rdata;
    assign i_err     = r_i_err;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign i_stall   = i_req & ~r_i_done;
    assign d_stall   = d_req & ~r_d_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A behavioural memory
//                answers strobes after a configurable latency with data derived
//                from the address; expected completions are queued when a
//                request is driven and compared when a done pulse appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req, i_flush, i_done, i_err, i_stall;
    logic [15:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_done, d_err, d_stall;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        mem_rd, mem_wr, mem_done, mem_err;
    logic [15:0] mem_addr, mem_wdata, mem_dout;

    mem_port_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .STARVE_MAX (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .d_stall   (d_stall),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_dout  (mem_dout),
        .mem_done  (mem_done),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_d;
        logic [15:0] rdata;
        bit          err;
    } exp_t;
    exp_t sb[$];

    logic [15:0] m_i_rdata = 16'h0000;
    logic [15:0] m_d_rdata = 16'h0000;

    int cfg_lat = 1;
    bit cfg_err = 1'b0;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_i(input logic [15:0] a, input bit e);
        m_i_rdata = mem_val(a);
        sb.push_back('{is_d: 1'b0, rdata: m_i_rdata, err: e});
    endtask

    task automatic push_d(input bit wr, input logic [15:0] a, input bit e);
        if (!wr) m_d_rdata = mem_val(a);
        sb.push_back('{is_d: 1'b1, rdata: m_d_rdata, err: e});
    endtask

    // Waits (from a cycle start) for the selected done pulse; cyc = edges taken.
    task automatic wait_done(input bit is_d, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!(is_d ? d_done : i_done) && cyc < 60);
        if (!(is_d ? d_done : i_done)) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got no done, expected done within 60 cycles", is_d ? "d" : "i");
        end
    endtask

    // Behavioural memory: answers a held strobe after cfg_lat cycles.
    initial begin : mem_model
        int cnt;
        cnt      = 0;
        mem_done = 1'b0;
        mem_err  = 1'b0;
        mem_dout = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (mem_done) begin
                mem_done = 1'b0;
                mem_err  = 1'b0;
                mem_dout = 16'($urandom);
                cnt      = 0;
            end else if (mem_rd || mem_wr) begin
                cnt++;
                if (cnt >= cfg_lat) begin
                    mem_done = 1'b1;
                    mem_dout = mem_val(mem_addr);
                    mem_err  = cfg_err;
                end else begin
                    mem_dout = 16'($urandom);
                end
            end else begin
                cnt      = 0;
                mem_dout = 16'($urandom);
            end
        end
    end

    task automatic check_done(input bit is_d);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: got %s done pulse, expected none", is_d ? "d" : "i");
        end else begin
            e = sb.pop_front();
            chk("done_kind", 32'(is_d), 32'(e.is_d));
            chk(is_d ? "d_rdata" : "i_rdata", is_d ? d_rdata : i_rdata, e.rdata);
            chk(is_d ? "d_err" : "i_err", is_d ? d_err : i_err, 32'(e.err));
        end
    endtask

    always @(negedge clk) begin
        if (i_done) check_done(1'b0);
        if (d_done) check_done(1'b1);
    end

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        bit          err;
        bit          exp_rd;
        bit          exp_wr;
    } vec_t;
    vec_t vecs[8];

    initial begin : stim
        vec_t v;
        int   cyc, cyc_d, cyc_i, dn;

        vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 16'h0044, 16'h0000, 3, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'h0032, 16'h0000, 1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 16'h0034, 16'h5A5A, 2, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 16'h0048, 16'h0000, 1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        i_req = 1'b0; i_addr = 16'h0; i_flush = 1'b0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
        #2 rst = 1'b0;
        #1;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_i_done", i_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single-requester vectors, issued back to back.
        for (int k = 0; k < 8; k++) begin
            v = vecs[k];
            cfg_lat = v.lat;
            cfg_err = v.err;
            if (v.is_d) begin
                d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
                push_d(v.wr, v.addr, v.err);
            end else begin
                i_addr = v.addr; i_req = 1'b1;
                push_i(v.addr, v.err);
            end
            @(posedge clk); #1;
            chk("strobe_rd", mem_rd, 32'(v.exp_rd));
            chk("strobe_wr", mem_wr, 32'(v.exp_wr));
            chk("strobe_addr", mem_addr, v.addr);
            if (v.wr) chk("strobe_wdata", mem_wdata, v.wdata);
            chk("stall_busy", v.is_d ? d_stall : i_stall, 1);
            cyc = 1;
            while (!(v.is_d ? d_done : i_done) && cyc < 60) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("latency", cyc, v.lat + 1);
            chk("stall_at_done", v.is_d ? d_stall : i_stall, 0);
            i_req = 1'b0;
            d_req = 1'b0;
        end

        // Simultaneous requests: D write first, I in the IDLE cycle after.
        cfg_lat = 1; cfg_err = 1'b0;
        push_d(1'b1, 16'h0100, 1'b0);
        push_i(16'h0200, 1'b0);
        d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF; d_req = 1'b1;
        i_addr = 16'h0200; i_req = 1'b1;
        fork
            begin
                @(posedge clk); #1;
                chk("simul_mem_wr", mem_wr, 1);
                chk("simul_mem_rd", mem_rd, 0);
                chk("simul_wdata", mem_wdata, 16'hBEEF);
                chk("simul_addr", mem_addr, 16'h0100);
            end
            begin wait_done(1'b1, cyc_d); d_req = 1'b0; chk("simul_d_lat", cyc_d, 2); end
            begin wait_done(1'b0, cyc_i); i_req = 1'b0; chk("simul_i_lat", cyc_i, 4); end
        join

        // Starvation bound: four D reads, then I, then D again.
        for (int n = 0; n < 4; n++) push_d(1'b0, 16'h0400, 1'b0);
        push_i(16'h0300, 1'b0);
        push_d(1'b0, 16'h0400, 1'b0);
        d_wr = 1'b0; d_addr = 16'h0400; d_req = 1'b1;
        i_addr = 16'h0300; i_req = 1'b1;
        dn = 0;
        fork
            begin
                wait_done(1'b0, cyc_i);
                i_req = 1'b0;
                chk("starve_i_lat", cyc_i, 10);
                chk("starve_d_before_i", dn, 4);
            end
            begin
                for (int n = 0; n < 5; n++) begin
                    wait_done(1'b1, cyc_d);
                    dn++;
                end
                d_req = 1'b0;
            end
        join
        chk("starve_d_total", dn, 5);

        // Flush during BUSY_I: access completes silently, old i_rdata kept.
        cfg_lat = 3;
        i_addr = 16'h0500; i_req = 1'b1;
        @(posedge clk); #1;
        chk("flush_strobe", mem_rd, 1);
        i_flush = 1'b1; i_req = 1'b0;
        @(posedge clk); #1;
        i_flush = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("flush_rdata_kept", i_rdata, m_i_rdata);
        chk("flush_strobe_dropped", mem_rd, 0);
        cfg_lat = 1;
        push_i(16'h0600, 1'b0);
        i_addr = 16'h0600; i_req = 1'b1;
        wait_done(1'b0, cyc);
        i_req = 1'b0;
        chk("post_flush_lat", cyc, 2);

        // Asynchronous reset in the middle of BUSY_D.
        cfg_lat = 20;
        d_wr = 1'b0; d_addr = 16'h0700; d_req = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_strobe", mem_rd, 1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_mem_rd", mem_rd, 0);
        chk("rstmid_mem_wr", mem_wr, 0);
        chk("rstmid_d_done", d_done, 0);
        chk("rstmid_d_rdata", d_rdata, 0);
        m_d_rdata = 16'h0000;
        m_i_rdata = 16'h0000;
        d_req = 1'b0;
        #3 rst = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("rstmid_idle_rd", mem_rd, 0);
        cfg_lat = 1;
        push_i(16'h0800, 1'b0);
        i_addr = 16'h0800; i_req = 1'b1;
        wait_done(1'b0, cyc);
        i_req = 1'b0;
        chk("post_rst_lat", cyc, 2);
        repeat (3) begin @(posedge clk); #1; end

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
